// File: rtl/loader_pkg.sv
// Shared types and constants for the loader RAM writer: state encoding, widths,
// default region placement and the word-to-byte address helper.
package loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_MAX_WORDS = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    WAIT_ACK    = 2'd2,
    WAIT_WE_LOW = 2'd3
  } loader_state_e;

  // Byte address of word 'idx'; the shift and add both wrap modulo 2^32.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [WORD_W-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/loader_csum.sv
// Running 32-bit checksum of committed words. Only compiled and instantiated
// when LOADER_CSUM_EN is defined.
`ifdef LOADER_CSUM_EN
module loader_csum
  import loader_pkg::*;
(
  input  logic              clk27mhz,
  input  logic              rst,
  input  logic              add_en,
  input  logic [WORD_W-1:0] add_val,
  output logic [WORD_W-1:0] csum
);

  always_ff @(posedge clk27mhz or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (add_en) begin
      csum <= csum + add_val;
    end
  end

endmodule
`endif

// File: rtl/loader_ram_writer.sv
// Commits each word handed over by the sector loader to RAM with a req/ack write.
// Define LOADER_CSUM_EN to add a running checksum of committed words on csum.
module loader_ram_writer
  import loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [WORD_W-1:0] MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk27mhz,
  input  logic              rst,
  input  logic [WORD_W-1:0] DATA,
  input  logic              WE,
  input  logic              DONE,
  output logic [7:0]        w_ctrl_state,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic [WORD_W-1:0] words_written,
  output logic              overflow,
  output logic              boot_ready,
  output logic [WORD_W-1:0] csum
);

  loader_state_e state;

  assign w_ctrl_state = {6'b0, state};

  always_ff @(posedge clk27mhz or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      words_written <= '0;
      overflow      <= 1'b0;
      boot_ready    <= 1'b0;
    end else begin
      if (DONE && (state == IDLE) && !WE) begin
        boot_ready <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (WE) begin
            mem_wdata <= DATA;
            mem_addr  <= word_addr(BASE_ADDR, words_written);
            if (words_written < MAX_WORDS) begin
              state <= REQ;
            end else begin
              overflow <= 1'b1;
              state    <= WAIT_WE_LOW;
            end
          end
        end
        REQ: begin
          mem_req <= 1'b1;
          mem_be  <= 4'hF;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_be  <= 4'h0;
            if (words_written != '1) begin
              words_written <= words_written + 1'b1;
            end
            state <= WAIT_WE_LOW;
          end
        end
        WAIT_WE_LOW: begin
          // Wait for WE to fall so a long pulse commits only one word.
          if (!WE) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CSUM_EN
  logic commit;
  assign commit = (state == WAIT_ACK) && mem_ack;

  loader_csum u_csum (
    .clk27mhz (clk27mhz),
    .rst      (rst),
    .add_en   (commit),
    .add_val  (mem_wdata),
    .csum     (csum)
  );
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_loader_ram_writer.sv
// Directed bench for loader_ram_writer: instance 0 uses default parameters,
// instance 1 uses MAX_WORDS=2 for the overflow case.
module tb_loader_ram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in [2];
  logic        we      [2];
  logic        done    [2];
  logic        ack     [2];
  logic [7:0]  ctrl    [2];
  logic        req     [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  be      [2];
  logic [31:0] ww      [2];
  logic        ovf     [2];
  logic        ready   [2];
  logic [31:0] csum    [2];

  int          wr_cnt    [2];
  logic [31:0] last_addr [2];
  logic [31:0] last_data [2];
  logic [3:0]  last_be   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  loader_ram_writer u_dut0 (
    .clk27mhz      (clk),
    .rst           (rst),
    .DATA          (data_in[0]),
    .WE            (we[0]),
    .DONE          (done[0]),
    .w_ctrl_state  (ctrl[0]),
    .mem_req       (req[0]),
    .mem_addr      (addr[0]),
    .mem_wdata     (wdata[0]),
    .mem_be        (be[0]),
    .mem_ack       (ack[0]),
    .words_written (ww[0]),
    .overflow      (ovf[0]),
    .boot_ready    (ready[0]),
    .csum          (csum[0])
  );

  loader_ram_writer #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (32'd2)
  ) u_dut1 (
    .clk27mhz      (clk),
    .rst           (rst),
    .DATA          (data_in[1]),
    .WE            (we[1]),
    .DONE          (done[1]),
    .w_ctrl_state  (ctrl[1]),
    .mem_req       (req[1]),
    .mem_addr      (addr[1]),
    .mem_wdata     (wdata[1]),
    .mem_be        (be[1]),
    .mem_ack       (ack[1]),
    .words_written (ww[1]),
    .overflow      (ovf[1]),
    .boot_ready    (ready[1]),
    .csum          (csum[1])
  );

  // RAM-side view: every cycle with req and ack both high is one accepted write.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req[i] && ack[i]) begin
        wr_cnt[i]++;
        last_addr[i] = addr[i];
        last_data[i] = wdata[i];
        last_be[i]   = be[i];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one word on instance i (call just after a negedge). The RAM acks
  // 'delay' cycles after mem_req is first seen; WE is kept high for 'hold'
  // cycles of WAIT_WE_LOW. lat = negedges from WE rising to words_written moving.
  task automatic send_word(input int i, input logic [31:0] d, input int delay,
                           input int hold, output int lat);
    int          ack_cnt;
    int          held;
    logic [31:0] ww0;
    logic [31:0] a0;
    logic [31:0] w0;
    logic        bad;
    logic        fin;
    ww0 = ww[i]; ack_cnt = -1; held = 0; bad = 1'b0; fin = 1'b0; lat = -1;
    a0 = '0; w0 = '0;
    data_in[i] = d;
    we[i] = 1'b1;
    for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
      @(negedge clk);
      ack[i] = 1'b0;
      if (lat < 0 && ww[i] != ww0) lat = cyc;
      if (ctrl[i] == 8'd2) begin
        if (ack_cnt < 0) begin
          a0 = addr[i];
          w0 = wdata[i];
          ack_cnt = 0;
        end
        if (!req[i] || addr[i] != a0 || wdata[i] != w0) bad = 1'b1;
        if (ack_cnt == delay) ack[i] = 1'b1;
        ack_cnt++;
      end
      if (we[i] && held > 0 && ctrl[i] != 8'd3) bad = 1'b1;
      if (we[i] && ctrl[i] == 8'd3) held++;
      if (we[i] && ctrl[i] != 8'd0 && held >= hold) we[i] = 1'b0;
      if (ctrl[i] == 8'd0 && !we[i]) fin = 1'b1;
    end
    we[i] = 1'b0;
    ack[i] = 1'b0;
    check_eq("req_stable", {31'b0, bad}, 32'd0);
    check_eq("word_done", {31'b0, fin}, 32'd1);
  endtask

  logic [31:0] exp_sum;
  logic [31:0] d;
  int          lat;
  int          snap;
  logic        hit;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      data_in[i] = '0; we[i] = 1'b0; done[i] = 1'b0; ack[i] = 1'b0;
      wr_cnt[i] = 0; last_addr[i] = '0; last_data[i] = '0; last_be[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_state", {24'b0, ctrl[0]}, 32'd0);
    check_eq("rst_req", {31'b0, req[0]}, 32'd0);
    check_eq("rst_addr", addr[0], 32'd0);
    check_eq("rst_wdata", wdata[0], 32'd0);
    check_eq("rst_be", {28'b0, be[0]}, 32'd0);
    check_eq("rst_ww", ww[0], 32'd0);
    check_eq("rst_ovf", {31'b0, ovf[1]}, 32'd0);
    check_eq("rst_ready", {31'b0, ready[0]}, 32'd0);
    check_eq("rst_csum", csum[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word, ack one cycle after mem_req.
    send_word(0, 32'hDEAD_BEEF, 1, 0, lat);
    check_eq("w1_writes", wr_cnt[0], 32'd1);
    check_eq("w1_addr", last_addr[0], 32'h0);
    check_eq("w1_data", last_data[0], 32'hDEAD_BEEF);
    check_eq("w1_be", {28'b0, last_be[0]}, 32'hF);
    check_eq("w1_ww", ww[0], 32'd1);
    check_eq("w1_state", {24'b0, ctrl[0]}, 32'd0);
    check_eq("w1_req_low", {31'b0, req[0]}, 32'd0);
    check_eq("w1_lat", lat, 32'd4);

    // Ack in the cycle mem_req rises: minimum latency.
    send_word(0, 32'h1234_5678, 0, 0, lat);
    check_eq("w2_lat", lat, 32'd3);
    check_eq("w2_addr", last_addr[0], 32'h4);

    // Ack stalled 10 cycles.
    send_word(0, 32'hA5A5_A5A5, 10, 0, lat);
    check_eq("stall_writes", wr_cnt[0], 32'd3);
    check_eq("stall_ww", ww[0], 32'd3);
    check_eq("stall_lat", lat, 32'd13);
    check_eq("stall_addr", last_addr[0], 32'h8);

    // WE held 20 cycles past the ack.
    send_word(0, 32'h0BAD_F00D, 0, 20, lat);
    check_eq("hold_writes", wr_cnt[0], 32'd4);
    check_eq("hold_ww", ww[0], 32'd4);

    // Stray acks while idle are ignored.
    ack[0] = 1'b1;
    repeat (3) @(negedge clk);
    ack[0] = 1'b0;
    @(negedge clk);
    check_eq("stray_ack_ww", ww[0], 32'd4);
    check_eq("stray_ack_state", {24'b0, ctrl[0]}, 32'd0);

    // Reset while waiting for ack; a late ack after release must not count.
    data_in[0] = 32'hC0FF_EE00;
    we[0] = 1'b1;
    for (int k = 0; k < 10 && ctrl[0] != 8'd2; k++) begin
      @(negedge clk);
      if (ctrl[0] != 8'd0) we[0] = 1'b0;
    end
    we[0] = 1'b0;
    check_eq("rw_in_wait_ack", {24'b0, ctrl[0]}, 32'd2);
    snap = wr_cnt[0];
    rst = 1'b1;
    #1;
    check_eq("rw_async_state", {24'b0, ctrl[0]}, 32'd0);
    check_eq("rw_async_req", {31'b0, req[0]}, 32'd0);
    @(negedge clk);
    check_eq("rw_addr", addr[0], 32'd0);
    check_eq("rw_wdata", wdata[0], 32'd0);
    check_eq("rw_ww", ww[0], 32'd0);
    rst = 1'b0;
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    @(negedge clk);
    check_eq("rw_late_ack_ww", ww[0], 32'd0);
    check_eq("rw_late_ack_writes", wr_cnt[0], snap);
    check_eq("rw_state", {24'b0, ctrl[0]}, 32'd0);

    // One 512-byte sector, then DONE.
    exp_sum = '0;
    for (int k = 0; k < 128; k++) begin
      d = 32'h1000_0000 + k;
      exp_sum += d;
      send_word(0, d, k % 3, 0, lat);
    end
    check_eq("sec_ww", ww[0], 32'd128);
    check_eq("sec_last_addr", last_addr[0], 32'h1FC);
    check_eq("sec_last_data", last_data[0], 32'h1000_007F);
`ifdef LOADER_CSUM_EN
    check_eq("sec_csum", csum[0], exp_sum);
`else
    check_eq("sec_csum", csum[0], 32'd0);
`endif
    check_eq("sec_not_ready", {31'b0, ready[0]}, 32'd0);
    done[0] = 1'b1;
    @(negedge clk);
    check_eq("sec_ready", {31'b0, ready[0]}, 32'd1);
    done[0] = 1'b0;

    // Writes continue after boot_ready.
    send_word(0, 32'hFEED_FACE, 1, 0, lat);
    check_eq("post_ww", ww[0], 32'd129);
    check_eq("post_addr", last_addr[0], 32'h200);
    check_eq("post_ready", {31'b0, ready[0]}, 32'd1);

    // Overflow on the MAX_WORDS=2 instance.
    send_word(1, 32'h1111_1111, 0, 0, lat);
    send_word(1, 32'h2222_2222, 1, 0, lat);
    check_eq("ovf_before", {31'b0, ovf[1]}, 32'd0);
    check_eq("ovf_addr1", last_addr[1], 32'h4);
    send_word(1, 32'h3333_3333, 0, 0, lat);
    check_eq("ovf_flag", {31'b0, ovf[1]}, 32'd1);
    check_eq("ovf_writes", wr_cnt[1], 32'd2);
    check_eq("ovf_ww", ww[1], 32'd2);
    check_eq("ovf_last_addr", last_addr[1], 32'h4);
    check_eq("ovf_state", {24'b0, ctrl[1]}, 32'd0);
    hit = (ovf[0] == 1'b0);
    check_eq("ovf_other_inst", {31'b0, hit}, 32'd1);
`ifdef LOADER_CSUM_EN
    check_eq("ovf_csum", csum[1], 32'h3333_3333);
`else
    check_eq("ovf_csum", csum[1], 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
